nand3_truth_sequencer: RTL and testbench

- Self-checking stimulus controller for the 3-input NAND gate (inputs a, b, c; output y).
- On a start request it walks the 8 input combinations in binary order {a,b,c} = 000 to 111.
- For each vector it holds the inputs for a programmable settle time, samples the gate output, and compares it against an expected truth table.
- Sits beside the gate instance in lab/bring-up builds and replaces the hand-written 8-step stimulus sequence with a clocked, reusable checker.

---
 rtl/nand3_truth_sequencer_if.sv | 27 ++
 rtl/nand3_truth_sequencer.sv | 125 ++++++++++++
 tb/tb_nand3_truth_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nand3_truth_sequencer_if.sv
// Signal bundle between the NAND3 truth-table sequencer and the gate under test.
// The master side is the sequencer; the slave side is the gate/harness that drives start and dut_y.
`timescale 1ns/1ps
interface nand3_truth_sequencer_if;
    logic       start;
    logic       dut_y;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] result;
    logic [7:0] fail_mask;
    logic [3:0] err_count;

    // start is a level request sampled only while idle; done is a one-cycle completion pulse.
    modport master (
        input  start, dut_y,
        output a, b, c, busy, done, pass, result, fail_mask, err_count
    );

    modport slave (
        output start, dut_y,
        input  a, b, c, busy, done, pass, result, fail_mask, err_count
    );
endinterface

// File: rtl/nand3_truth_sequencer.sv
// Walks the 8 input vectors of a 3-input gate, holds each for HOLD_CYCLES,
// samples the gate output and scores it against the EXPECT truth table.
`timescale 1ns/1ps
module nand3_truth_sequencer #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  EXPECT      = 8'h7F
) (
    input  logic                          clk,
    input  logic                          rst,
    nand3_truth_sequencer_if.master       bus,
    output logic [1:0]                    dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] result_q, result_d;
    logic [7:0] fail_mask_q, fail_mask_d;
    logic [3:0] err_count_q, err_count_d;
    logic       miss;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        result_d    = result_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        miss        = bus.dut_y ^ EXPECT[idx_q];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d       = 3'd0;
                    cnt_d       = HOLD_RELOAD;
                    result_d    = 8'd0;
                    fail_mask_d = 8'd0;
                    err_count_d = 4'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                result_d[idx_q]    = bus.dut_y;
                fail_mask_d[idx_q] = miss;
                err_count_d        = err_count_q + {3'd0, miss};
                if (idx_q == 3'd7) begin
                    // done and pass are registered, so they are set on the edge entering DONE
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == 4'd0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = HOLD_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            result_q    <= 8'd0;
            fail_mask_q <= 8'd0;
            err_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            result_q    <= result_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    // The vector index doubles as the applied {a,b,c}, so it stays at 111 after a sweep.
    assign bus.a         = idx_q[2];
    assign bus.b         = idx_q[1];
    assign bus.c         = idx_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.result    = result_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_nand3_truth_sequencer.sv
// Bench for nand3_truth_sequencer: randomized gate faults scored against a truth-table
// reference model, plus reset-abort, ignored-start and back-to-back sweep checks.
`timescale 1ns/1ps
module tb_nand3_truth_sequencer;

  localparam int HOLD2  = 2;
  localparam int SWEEP2 = 8 * (HOLD2 + 1);
  localparam int HOLD1  = 1;
  localparam int SWEEP1 = 8 * (HOLD1 + 1);
  localparam int PER1   = SWEEP1 + 2;

  typedef struct {
    logic [7:0] result;
    logic [7:0] fail;
    logic [3:0] err;
    logic       pass;
    int         accept;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fault_mode = 0;
  logic [7:0] rand_tt = 8'h00;
  exp_t exp_q[$];

  logic [1:0] dbg2, dbg1;

  nand3_truth_sequencer_if bus2 ();
  nand3_truth_sequencer_if bus1 ();

  nand3_truth_sequencer #(.HOLD_CYCLES(HOLD2), .EXPECT(8'h7F)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2)
  );
  nand3_truth_sequencer #(.HOLD_CYCLES(HOLD1), .EXPECT(8'h7F)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- gate under test and reference model ----------------
  function automatic logic gate(input int mode, input logic [7:0] tt, input logic [2:0] v);
    case (mode)
      0: gate = ~(v[2] & v[1] & v[0]);
      1: gate = ~(v[2] & v[1]);
      2: gate = 1'b1;
      3: gate = 1'b0;
      default: gate = tt[v];
    endcase
  endfunction

  function automatic exp_t model(input int mode, input logic [7:0] tt, input int accept);
    exp_t e;
    logic [7:0] golden;
    for (int i = 0; i < 8; i++) begin
      e.result[i] = gate(mode, tt, 3'(i));
      golden[i]   = (i != 7);
    end
    e.fail   = e.result ^ golden;
    e.err    = 4'($countones(e.fail));
    e.pass   = (e.fail == 8'h00);
    e.accept = accept;
    return e;
  endfunction

  assign bus2.dut_y = gate(fault_mode, rand_tt, {bus2.a, bus2.b, bus2.c});
  assign bus1.dut_y = ~(bus1.a & bus1.b & bus1.c);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abc"},  {29'd0, bus2.a, bus2.b, bus2.c}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus2.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus2.done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, bus2.pass}, 32'd0);
    chk({tag, "_result"}, {24'd0, bus2.result}, 32'd0);
    chk({tag, "_fail_mask"}, {24'd0, bus2.fail_mask}, 32'd0);
    chk({tag, "_err_count"}, {28'd0, bus2.err_count}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg2}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus2.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_latency", cyc - e.accept, SWEEP2);
            chk("result", {24'd0, bus2.result}, {24'd0, e.result});
            chk("fail_mask", {24'd0, bus2.fail_mask}, {24'd0, e.fail});
            chk("err_count", {28'd0, bus2.err_count}, {28'd0, e.err});
            chk("pass", {31'd0, bus2.pass}, {31'd0, e.pass});
            chk("abc_after_sweep", {29'd0, bus2.a, bus2.b, bus2.c}, 32'd7);
          end
        end else if (exp_q.size() != 0) begin
          int k;
          k = cyc - exp_q[0].accept;
          if (k >= SWEEP2) begin
            chk("done_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
          end else if (k >= 0) begin
            chk("vector", {29'd0, bus2.a, bus2.b, bus2.c}, k / (HOLD2 + 1));
            chk("busy", {31'd0, bus2.busy}, 32'd1);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_sweep(input int mode, input bit stray, input bit abort);
    @(negedge clk);
    fault_mode = mode;
    if (mode == 4) rand_tt = 8'($urandom);
    bus2.start = 1'b1;
    exp_q.push_back(model(mode, rand_tt, cyc + 1));
    @(negedge clk);
    bus2.start = 1'b0;
    if (abort) begin
      repeat (5 * (HOLD2 + 1)) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("abort");
      repeat (SWEEP2 + 4) @(negedge clk);
    end else begin
      if (stray) begin
        repeat (2 * (HOLD2 + 1)) @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
      end
      wait_drain();
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    chk("reset_dut1_busy", {31'd0, bus1.busy}, 32'd0);
    chk("reset_dut1_result", {24'd0, bus1.result}, 32'd0);

    run_sweep(0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    run_sweep(2, 1'b0, 1'b0);
    run_sweep(3, 1'b0, 1'b0);
    run_sweep(0, 1'b1, 1'b0);
    run_sweep(1, 1'b0, 1'b1);
    run_sweep(0, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      run_sweep(int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Start held high on the HOLD_CYCLES=1 instance: back-to-back sweeps, one idle cycle apart.
    begin
      int s;
      int k;
      @(negedge clk);
      bus1.start = 1'b1;
      s = cyc + 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        k = cyc - s;
        chk("h1_done", {31'd0, bus1.done}, {31'd0, (k % PER1) == SWEEP1});
        chk("h1_busy", {31'd0, bus1.busy}, {31'd0, (k % PER1) != (SWEEP1 + 1)});
        if (bus1.done) begin
          chk("h1_pass", {31'd0, bus1.pass}, 32'd1);
          chk("h1_result", {24'd0, bus1.result}, 32'h7F);
        end
      end
      bus1.start = 1'b0;
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
